ifm_out_fsm: RTL and testbench

- Read-side framer for the RX interface FIFOs: drains the 73-bit data FIFO and the 8-bit info FIFO written by the MAC receive path.
- Presents good frames as a 64-bit AXI-Stream master toward the DMA engine.
- Discards frames whose info word flags a MAC error (bit 0 set).
- Runs in the rx_clk domain on common-clock, first-word-fall-through (FWFT) FIFOs.

---
 rtl/ifm_pkg.sv | 12 +
 rtl/ifm_axis_oreg.sv | 31 +++
 rtl/ifm_out_fsm.sv | 75 +++++++
 tb/tb_ifm_out_fsm.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifm_pkg.sv
// ifm_pkg: shared state encodings and FIFO field positions for the RX interface FIFO framers
package ifm_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PASS = 2'd1,
    S_DROP = 2'd2
  } state_t;
  localparam int IFM_TLAST_BIT    = 72;
  localparam int IFM_TKEEP_MSB    = 71;
  localparam int IFM_TKEEP_LSB    = 64;
  localparam int IFM_INFO_ERR_BIT = 0;
endpackage

// File: rtl/ifm_axis_oreg.sv
// ifm_axis_oreg: single-entry registered AXI-Stream output stage
module ifm_axis_oreg
  import ifm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [72:0] din,
  input  logic        tready,
  output logic [63:0] tdata,
  output logic [7:0]  tkeep,
  output logic        tlast,
  output logic        tvalid
);
  // load a popped word, otherwise retire the pending beat once accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdata  <= '0;
      tkeep  <= '0;
      tlast  <= 1'b0;
      tvalid <= 1'b0;
    end else if (load) begin
      tdata  <= din[63:0];
      tkeep  <= din[IFM_TKEEP_MSB:IFM_TKEEP_LSB];
      tlast  <= din[IFM_TLAST_BIT];
      tvalid <= 1'b1;
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end
endmodule

// File: rtl/ifm_out_fsm.sv
// ifm_out_fsm: drains RX data/info FIFOs into AXI-Stream, dropping errored frames; IFM_OUT_STATS_EN adds frame counters
module ifm_out_fsm
  import ifm_pkg::*;
#(
  parameter int C_CNT_WIDTH = 32
) (
  input  logic                   rx_clk,
  input  logic                   sys_rst,
  input  logic [72:0]            data_fifo_rdata,
  input  logic                   data_fifo_empty,
  output logic                   data_fifo_rden,
  input  logic [7:0]             info_fifo_rdata,
  input  logic                   info_fifo_empty,
  output logic                   info_fifo_rden,
  output logic [63:0]            m_axis_tdata,
  output logic [7:0]             m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
`ifdef IFM_OUT_STATS_EN
  output logic [C_CNT_WIDTH-1:0] good_frame_cnt,
  output logic [C_CNT_WIDTH-1:0] drop_frame_cnt,
`endif
  output logic [3:0]             ifm_out_fsm_dbg
);
  state_t state, state_nxt;
  logic   pass_pop, drop_pop;
  logic   unused_info;
  assign unused_info = ^info_fifo_rdata[7:1];
  // state register; reset abandons any partial frame
  always_ff @(posedge rx_clk or posedge sys_rst) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end
  // pop decisions and next state; the info word is popped together with the tlast word
  always_comb begin
    pass_pop       = (state == S_PASS) && !data_fifo_empty && (!m_axis_tvalid || m_axis_tready);
    drop_pop       = (state == S_DROP) && !data_fifo_empty;
    data_fifo_rden = pass_pop || drop_pop;
    info_fifo_rden = data_fifo_rden && data_fifo_rdata[IFM_TLAST_BIT];
    state_nxt      = S_IDLE;
    case (state)
      S_IDLE:         state_nxt = info_fifo_empty ? S_IDLE :
                                  info_fifo_rdata[IFM_INFO_ERR_BIT] ? S_DROP : S_PASS;
      S_PASS, S_DROP: state_nxt = info_fifo_rden ? S_IDLE : state;
      default:        state_nxt = S_IDLE;
    endcase
  end
  ifm_axis_oreg u_oreg (
    .clk    (rx_clk),
    .rst    (sys_rst),
    .load   (pass_pop),
    .din    (data_fifo_rdata),
    .tready (m_axis_tready),
    .tdata  (m_axis_tdata),
    .tkeep  (m_axis_tkeep),
    .tlast  (m_axis_tlast),
    .tvalid (m_axis_tvalid)
  );
  assign ifm_out_fsm_dbg = {m_axis_tvalid, 1'b0, state};
`ifdef IFM_OUT_STATS_EN
  // count completed frames by the state that consumed their tlast word
  always_ff @(posedge rx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      good_frame_cnt <= '0;
      drop_frame_cnt <= '0;
    end else begin
      if (info_fifo_rden && state == S_PASS) good_frame_cnt <= good_frame_cnt + C_CNT_WIDTH'(1);
      if (info_fifo_rden && state == S_DROP) drop_frame_cnt <= drop_frame_cnt + C_CNT_WIDTH'(1);
    end
  end
`else
  localparam int unused_cnt_width = C_CNT_WIDTH;
`endif
endmodule

// File: tb/tb_ifm_out_fsm.sv
// tb_ifm_out_fsm: directed self-checking bench for ifm_out_fsm with modelled FWFT FIFOs
module tb_ifm_out_fsm;
  logic        rx_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [72:0] data_fifo_rdata;
  logic        data_fifo_empty;
  logic        data_fifo_rden;
  logic [7:0]  info_fifo_rdata;
  logic        info_fifo_empty;
  logic        info_fifo_rden;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [3:0]  ifm_out_fsm_dbg;
`ifdef IFM_OUT_STATS_EN
  logic [31:0] good_frame_cnt;
  logic [31:0] drop_frame_cnt;
`endif

  ifm_out_fsm #(.C_CNT_WIDTH(32)) dut (
    .rx_clk          (rx_clk),
    .sys_rst         (sys_rst),
    .data_fifo_rdata (data_fifo_rdata),
    .data_fifo_empty (data_fifo_empty),
    .data_fifo_rden  (data_fifo_rden),
    .info_fifo_rdata (info_fifo_rdata),
    .info_fifo_empty (info_fifo_empty),
    .info_fifo_rden  (info_fifo_rden),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tkeep    (m_axis_tkeep),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
`ifdef IFM_OUT_STATS_EN
    .good_frame_cnt  (good_frame_cnt),
    .drop_frame_cnt  (drop_frame_cnt),
`endif
    .ifm_out_fsm_dbg (ifm_out_fsm_dbg)
  );

  always #5 rx_clk = ~rx_clk;

  // FWFT FIFO models: the initial block writes, the monitor pops
  logic [72:0] dmem [0:255];
  logic [7:0]  imem [0:63];
  int dwp = 0, drp = 0, iwp = 0, irp = 0;
  logic hold = 1'b0;
  assign data_fifo_rdata = dmem[drp[7:0]];
  assign data_fifo_empty = hold || (drp == dwp);
  assign info_fifo_rdata = imem[irp[5:0]];
  assign info_fifo_empty = (irp == iwp);

  int tests = 0, fails = 0;
  int dpops = 0, ipops = 0, ob = 0;
  int viol_empty = 0, viol_bp = 0, viol_gap = 0, viol_stable = 0;
  logic        pend = 1'b0, prev_ipop = 1'b0;
  logic [72:0] save = '0;
  logic [72:0] cap [0:255];

  always @(posedge rx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      drp <= dwp;
      irp <= iwp;
      pend <= 1'b0;
      prev_ipop <= 1'b0;
    end else begin
      if (data_fifo_rden) begin drp <= drp + 1; dpops <= dpops + 1; end
      if (info_fifo_rden) begin irp <= irp + 1; ipops <= ipops + 1; end
      if ((data_fifo_rden && data_fifo_empty) || (info_fifo_rden && info_fifo_empty)) viol_empty <= viol_empty + 1;
      if (data_fifo_rden && m_axis_tvalid && !m_axis_tready) viol_bp <= viol_bp + 1;
      if (prev_ipop && data_fifo_rden) viol_gap <= viol_gap + 1;
      prev_ipop <= info_fifo_rden;
      if (pend && (!m_axis_tvalid || {m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== save)) viol_stable <= viol_stable + 1;
      pend <= m_axis_tvalid && !m_axis_tready;
      save <= {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready) begin
        cap[ob[7:0]] <= {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        ob <= ob + 1;
      end
    end
  end

  function automatic logic [72:0] w(input logic [7:0] f, input logic [7:0] i, input logic [7:0] k, input logic l);
    return {l, k, 24'hC0FFEE, f, 16'h0000, i, 8'h5A};
  endfunction

  function automatic logic [72:0] fw(input logic [7:0] f, input int i, input int n, input logic [7:0] klast);
    return w(f, 8'(i), (i == n - 1) ? klast : 8'hFF, i == n - 1);
  endfunction

  task automatic push_frame(input logic [7:0] f, input int n, input logic [7:0] klast, input logic err);
    for (int i = 0; i < n; i++) begin
      dmem[dwp[7:0]] = fw(f, i, n, klast);
      dwp = dwp + 1;
    end
    imem[iwp[5:0]] = {7'h00, err};
    iwp = iwp + 1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge rx_clk);
    tests++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
    tests++; if (m_axis_tlast !== 1'b0) begin fails++; $display("FAIL reset_tlast got %b want 0", m_axis_tlast); end
    tests++; if (m_axis_tdata !== 64'h0) begin fails++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata); end
    tests++; if (m_axis_tkeep !== 8'h00) begin fails++; $display("FAIL reset_tkeep got %h want 00", m_axis_tkeep); end
    tests++; if (ifm_out_fsm_dbg !== 4'h0) begin fails++; $display("FAIL reset_dbg got %h want 0", ifm_out_fsm_dbg); end
    tests++; if (data_fifo_rden !== 1'b0 || info_fifo_rden !== 1'b0) begin fails++; $display("FAIL reset_rden got %b%b want 00", data_fifo_rden, info_fifo_rden); end
    sys_rst = 1'b0;
    repeat (2) @(negedge rx_clk);
  endtask

  task automatic test_good_frame;
    int b0 = ob, d0 = dpops, i0 = ipops;
    m_axis_tready = 1'b1;
    push_frame(8'h01, 3, 8'h0F, 1'b0);
    @(posedge rx_clk); #1;
    tests++; if (ifm_out_fsm_dbg !== 4'b0001) begin fails++; $display("FAIL good_lat1_dbg got %b want 0001", ifm_out_fsm_dbg); end
    tests++; if (data_fifo_rden !== 1'b1) begin fails++; $display("FAIL good_first_pop got %b want 1", data_fifo_rden); end
    @(posedge rx_clk); #1;
    tests++; if (m_axis_tvalid !== 1'b1) begin fails++; $display("FAIL good_lat2_tvalid got %b want 1", m_axis_tvalid); end
    repeat (8) @(negedge rx_clk);
    tests++; if (ob - b0 !== 3) begin fails++; $display("FAIL good_beats got %0d want 3", ob - b0); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (cap[b0 + i] !== fw(8'h01, i, 3, 8'h0F)) begin fails++; $display("FAIL good_beat%0d got %h want %h", i, cap[b0 + i], fw(8'h01, i, 3, 8'h0F)); end
    end
    tests++; if (ipops - i0 !== 1 || dpops - d0 !== 3) begin fails++; $display("FAIL good_pops got info %0d data %0d want 1 3", ipops - i0, dpops - d0); end
  endtask

  task automatic test_drop_frame;
    int b0 = ob, i0 = ipops;
`ifdef IFM_OUT_STATS_EN
    logic [31:0] dc0 = drop_frame_cnt;
`endif
    m_axis_tready = 1'b1;
    push_frame(8'h02, 4, 8'hFF, 1'b1);
    @(posedge rx_clk); #1;
    tests++; if (ifm_out_fsm_dbg !== 4'b0010) begin fails++; $display("FAIL drop_enter_dbg got %b want 0010", ifm_out_fsm_dbg); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (data_fifo_rden !== 1'b1 || info_fifo_rden !== (i == 3)) begin fails++; $display("FAIL drop_pop%0d got %b%b want 1%b", i, data_fifo_rden, info_fifo_rden, i == 3); end
      tests++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL drop_tvalid%0d got %b want 0", i, m_axis_tvalid); end
      @(posedge rx_clk); #1;
    end
    tests++; if (ifm_out_fsm_dbg !== 4'b0000) begin fails++; $display("FAIL drop_exit_dbg got %b want 0000", ifm_out_fsm_dbg); end
    tests++; if (ob !== b0 || ipops - i0 !== 1) begin fails++; $display("FAIL drop_outputs got beats %0d info %0d want 0 1", ob - b0, ipops - i0); end
`ifdef IFM_OUT_STATS_EN
    tests++; if (drop_frame_cnt - dc0 !== 32'd1) begin fails++; $display("FAIL drop_cnt got %0d want 1", drop_frame_cnt - dc0); end
`endif
    @(negedge rx_clk);
  endtask

  task automatic test_backpressure;
    int b0 = ob;
    logic [7:0] pat = 8'b1010_1001;
    push_frame(8'h03, 5, 8'h3F, 1'b0);
    for (int c = 0; c < 40; c++) begin
      m_axis_tready = pat[c % 8];
      @(negedge rx_clk);
    end
    m_axis_tready = 1'b1;
    repeat (4) @(negedge rx_clk);
    tests++; if (ob - b0 !== 5) begin fails++; $display("FAIL bp_beats got %0d want 5", ob - b0); end
    for (int i = 0; i < 5; i++) begin
      tests++; if (cap[b0 + i] !== fw(8'h03, i, 5, 8'h3F)) begin fails++; $display("FAIL bp_beat%0d got %h want %h", i, cap[b0 + i], fw(8'h03, i, 5, 8'h3F)); end
    end
    tests++; if (viol_stable !== 0) begin fails++; $display("FAIL bp_stable got %0d want 0", viol_stable); end
    tests++; if (viol_bp !== 0) begin fails++; $display("FAIL bp_pop_when_full got %0d want 0", viol_bp); end
  endtask

  task automatic test_back_to_back;
    int b0 = ob, i0 = ipops, d0 = dpops;
    logic [72:0] exp_w [0:3];
`ifdef IFM_OUT_STATS_EN
    logic [31:0] gc0 = good_frame_cnt, dc0 = drop_frame_cnt;
`endif
    m_axis_tready = 1'b1;
    push_frame(8'h04, 2, 8'h01, 1'b0);
    push_frame(8'h05, 3, 8'hFF, 1'b1);
    push_frame(8'h06, 2, 8'h03, 1'b0);
    exp_w[0] = fw(8'h04, 0, 2, 8'h01);
    exp_w[1] = fw(8'h04, 1, 2, 8'h01);
    exp_w[2] = fw(8'h06, 0, 2, 8'h03);
    exp_w[3] = fw(8'h06, 1, 2, 8'h03);
    repeat (20) @(negedge rx_clk);
    tests++; if (ob - b0 !== 4) begin fails++; $display("FAIL b2b_beats got %0d want 4", ob - b0); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (cap[b0 + i] !== exp_w[i]) begin fails++; $display("FAIL b2b_beat%0d got %h want %h", i, cap[b0 + i], exp_w[i]); end
    end
    tests++; if (ipops - i0 !== 3 || dpops - d0 !== 7) begin fails++; $display("FAIL b2b_pops got info %0d data %0d want 3 7", ipops - i0, dpops - d0); end
    tests++; if (viol_gap !== 0) begin fails++; $display("FAIL b2b_idle_gap got %0d want 0", viol_gap); end
`ifdef IFM_OUT_STATS_EN
    tests++; if (good_frame_cnt - gc0 !== 32'd2 || drop_frame_cnt - dc0 !== 32'd1) begin fails++; $display("FAIL b2b_cnt got %0d %0d want 2 1", good_frame_cnt - gc0, drop_frame_cnt - dc0); end
`endif
  endtask

  task automatic test_stall;
    int b0 = ob;
    m_axis_tready = 1'b1;
    push_frame(8'h07, 4, 8'h7F, 1'b0);
    @(posedge rx_clk);
    @(posedge rx_clk);
    @(negedge rx_clk);
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++; if (data_fifo_rden !== 1'b0) begin fails++; $display("FAIL stall_rden%0d got %b want 0", c, data_fifo_rden); end
      @(negedge rx_clk);
    end
    hold = 1'b0;
    repeat (10) @(negedge rx_clk);
    tests++; if (ob - b0 !== 4) begin fails++; $display("FAIL stall_beats got %0d want 4", ob - b0); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (cap[b0 + i] !== fw(8'h07, i, 4, 8'h7F)) begin fails++; $display("FAIL stall_beat%0d got %h want %h", i, cap[b0 + i], fw(8'h07, i, 4, 8'h7F)); end
    end
    tests++; if (viol_empty !== 0) begin fails++; $display("FAIL stall_pop_when_empty got %0d want 0", viol_empty); end
  endtask

  task automatic test_reset_mid;
    int b0, d0;
    m_axis_tready = 1'b0;
    push_frame(8'h08, 4, 8'hFF, 1'b0);
    repeat (3) @(negedge rx_clk);
    m_axis_tready = 1'b1;
    @(negedge rx_clk);
    m_axis_tready = 1'b0;
    tests++; if (m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== fw(8'h08, 1, 4, 8'hFF)) begin fails++; $display("FAIL rst_pending got %b %h want 1 %h", m_axis_tvalid, m_axis_tdata, fw(8'h08, 1, 4, 8'hFF)); end
    #2 sys_rst = 1'b1;
    #1;
    tests++; if (m_axis_tvalid !== 1'b0 || ifm_out_fsm_dbg !== 4'h0) begin fails++; $display("FAIL rst_async got tvalid %b dbg %h want 0 0", m_axis_tvalid, ifm_out_fsm_dbg); end
    @(negedge rx_clk);
    sys_rst = 1'b0;
    m_axis_tready = 1'b1;
    b0 = ob;
    d0 = dpops;
    repeat (5) @(negedge rx_clk);
    tests++; if (m_axis_tvalid !== 1'b0 || ob !== b0 || dpops !== d0) begin fails++; $display("FAIL rst_quiet got tvalid %b beats %0d pops %0d want 0 0 0", m_axis_tvalid, ob - b0, dpops - d0); end
    push_frame(8'h09, 1, 8'h01, 1'b0);
    repeat (6) @(negedge rx_clk);
    tests++; if (ob - b0 !== 1 || cap[b0] !== fw(8'h09, 0, 1, 8'h01)) begin fails++; $display("FAIL rst_recover got %0d %h want 1 %h", ob - b0, cap[b0], fw(8'h09, 0, 1, 8'h01)); end
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_drop_frame;
    test_backpressure;
    test_back_to_back;
    test_stall;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
